// File: rtl/dbus_responder_pkg.sv
// Shared dbus request/response types and responder state encoding.
package dbus_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef logic [1:0] dresp_state_t;

    localparam dresp_state_t IDLE = 2'd0;
    localparam dresp_state_t WAIT = 2'd1;
    localparam dresp_state_t RESP = 2'd2;

endpackage

// File: rtl/dbus_responder_lfsr.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) supplying 0..3 extra latency cycles.
module dbus_resp_lfsr (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       adv_i,
    output logic [1:0] lat_add_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lat_add_o = lfsr_q[1:0];

endmodule

// File: rtl/dbus_responder.sv
// dbus slave: single outstanding request served from a 64-bit word store after LATENCY cycles.
// Optional random extra latency (0..3 cycles) under `DBUS_RESP_RAND_LAT_EN.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       err
);

    function automatic logic misaligned(input logic [2:0] a, input msize_t sz);
        case (sz)
            MSIZE2:  return a[0];
            MSIZE4:  return |a[1:0];
            MSIZE8:  return |a[2:0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_w, input logic [63:0] new_w,
                                                input strobe_t strb);
        logic [63:0] w;
        w = old_w;
        for (int unsigned i = 0; i < 8; i++) begin
            if (strb[i]) w[8*i +: 8] = new_w[8*i +: 8];
        end
        return w;
    endfunction

    logic [63:0] mem_q [2**DEPTH_LOG2];

    dresp_state_t    state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            bad_q, bad_d;
    logic [63:0]     addr_q;
    msize_t          size_q;
    strobe_t         strobe_q;
    logic [63:0]     wdata_q;

    logic            accept;
    logic            enter_resp;
    logic [4:0]      load;
    logic [63:0]     cur_addr;
    msize_t          cur_size;
    strobe_t         cur_strobe;
    logic [63:0]     off;
    logic            in_range;
    logic            cur_bad;
    logic [DEPTH_LOG2-1:0] idx;

`ifdef DBUS_RESP_RAND_LAT_EN
    logic [1:0] lat_add;

    dbus_resp_lfsr u_lfsr (
        .clk_i     (clk),
        .rst_ni    (rst),
        .adv_i     (accept),
        .lat_add_o (lat_add)
    );

    assign load = 5'(LATENCY - 1) + {3'b000, lat_add};
`else
    assign load = 5'(LATENCY - 1);
`endif

    // With a zero load the request goes to RESP from IDLE, so decode the live request there.
    assign cur_addr   = (state_q == IDLE) ? dreq.addr   : addr_q;
    assign cur_size   = (state_q == IDLE) ? dreq.size   : size_q;
    assign cur_strobe = (state_q == IDLE) ? dreq.strobe : strobe_q;

    assign off      = cur_addr - BASE_ADDR;
    assign in_range = (off >> (DEPTH_LOG2 + 3)) == '0;
    assign idx      = DEPTH_LOG2'(off >> 3);
    assign cur_bad  = !in_range || misaligned(cur_addr[2:0], cur_size);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        bad_d      = bad_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    accept = 1'b1;
                    if (load == '0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = load;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = '0;
                bad_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            bad_d   = cur_bad;
            rdata_d = (cur_strobe == '0 && !cur_bad) ? mem_q[idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            bad_q    <= 1'b0;
            addr_q   <= '0;
            size_q   <= MSIZE1;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            bad_q   <= bad_d;
            if (accept) begin
                addr_q   <= dreq.addr;
                size_q   <= dreq.size;
                strobe_q <= dreq.strobe;
                wdata_q  <= dreq.data;
            end
        end
    end

    // Commit happens on the edge leaving RESP; a reset before then clears state_q and drops it.
    always_ff @(posedge clk) begin
        if (state_q == RESP && strobe_q != '0 && !bad_q) begin
            mem_q[idx] <= merge_bytes(mem_q[idx], wdata_q, strobe_q);
        end
    end

    assign dresp.addr_ok = (state_q == RESP);
    assign dresp.data_ok = (state_q == RESP);
    assign dresp.data    = rdata_q;
    assign busy          = (state_q != IDLE);
    assign err           = (state_q == RESP) && bad_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed scoreboard bench for dbus_responder at LATENCY 2, 1 and 5.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    localparam int unsigned LAT [3] = '{2, 1, 5};

    typedef struct {
        logic [63:0] data;
        logic        err;
        int unsigned lat;
    } exp_t;

    logic        clk;
    logic        rst;
    dbus_req_t   req    [3];
    dbus_resp_t  resp   [3];
    logic        busy_w [3];
    logic        err_w  [3];

    exp_t        sb [$];
    int unsigned tests;
    int unsigned fails;
    logic [7:0]  lfsr_m [3];

    dbus_responder #(.LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .dreq(req[0]), .dresp(resp[0]), .busy(busy_w[0]), .err(err_w[0])
    );
    dbus_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .dreq(req[1]), .dresp(resp[1]), .busy(busy_w[1]), .err(err_w[1])
    );
    dbus_responder #(.LATENCY(5)) u_dut2 (
        .clk(clk), .rst(rst), .dreq(req[2]), .dresp(resp[2]), .busy(busy_w[2]), .err(err_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int sel, input string tag);
        chk({tag, "/busy"}, 64'(busy_w[sel]), 64'd0);
        chk({tag, "/data_ok"}, 64'(resp[sel].data_ok), 64'd0);
        chk({tag, "/data"}, resp[sel].data, 64'd0);
        chk({tag, "/err"}, 64'(err_w[sel]), 64'd0);
    endtask

    task automatic txn(input int sel, input string tag, input logic [63:0] addr, input msize_t size,
                       input strobe_t strb, input logic [63:0] wdata, input logic [63:0] exp_data,
                       input logic exp_err, input bit b2b, input bit hold, input bit corrupt);
        exp_t        e;
        int unsigned k;
        bit          got;
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = LAT[sel];
`ifdef DBUS_RESP_RAND_LAT_EN
        e.lat       += int'(lfsr_m[sel][1:0]);
        lfsr_m[sel]  = lfsr_next(lfsr_m[sel]);
`endif
        sb.push_back(e);
        if (!b2b) @(negedge clk);
        req[sel].valid  = 1'b1;
        req[sel].addr   = addr;
        req[sel].size   = size;
        req[sel].strobe = strb;
        req[sel].data   = wdata;
        if (b2b) @(posedge clk);
        k   = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (resp[sel].data_ok) begin
                got = 1'b1;
            end else begin
                chk({tag, "/wait_busy"}, 64'(busy_w[sel]), 64'd1);
                chk({tag, "/wait_data"}, resp[sel].data, 64'd0);
            end
            if (corrupt && k == 1) begin
                req[sel].addr   = ~addr;
                req[sel].strobe = 8'hFF;
                req[sel].data   = 64'hBAD0_BAD0_BAD0_BAD0;
            end
        end
        e = sb.pop_front();
        chk({tag, "/data_ok_seen"}, 64'(got), 64'd1);
        chk({tag, "/latency"}, 64'(k), 64'(e.lat));
        if (got) begin
            chk({tag, "/data"}, resp[sel].data, e.data);
            chk({tag, "/err"}, 64'(err_w[sel]), 64'(e.err));
            chk({tag, "/addr_ok"}, 64'(resp[sel].addr_ok), 64'd1);
            chk({tag, "/busy"}, 64'(busy_w[sel]), 64'd1);
        end
        if (!hold) begin
            req[sel].valid = 1'b0;
            @(posedge clk);
            #1;
            chk_idle(sel, {tag, "/after"});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i]    = '0;
            lfsr_m[i] = 8'hA5;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk_idle(i, "reset");
            chk("reset/addr_ok", 64'(resp[i].addr_ok), 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // basic, partial, range and alignment on LATENCY=2
        txn(0, "wr0",     64'h8000_0000, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 0, 0, 0);
        txn(0, "wr10",    64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 0, 0, 0);
        txn(0, "rd10",    64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 0, 0, 0);
        txn(0, "wr12",    64'h8000_0012, MSIZE2, 8'h0C, 64'h0000_0000_BEEF_0000, 64'd0, 1'b0, 0, 0, 0);
        txn(0, "rd10b",   64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BEEF_7788, 1'b0, 0, 0, 0);
        txn(0, "wr_oor",  64'h8000_8000, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 0, 0);
        txn(0, "rd0",     64'h8000_0000, MSIZE8, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 0);
        txn(0, "rd_mis",  64'h8000_0004, MSIZE8, 8'h00, 64'd0, 64'd0, 1'b1, 0, 0, 0);
        txn(0, "wr_mis",  64'h8000_0011, MSIZE2, 8'h06, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 0, 0);
        txn(0, "rd10c",   64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BEEF_7788, 1'b0, 0, 0, 0);
        txn(0, "wr_top",  64'h8000_7FF8, MSIZE8, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'd0, 1'b0, 0, 0, 0);
        txn(0, "rd_top",  64'h8000_7FF8, MSIZE8, 8'h00, 64'd0, 64'hCAFE_F00D_1234_5678, 1'b0, 0, 0, 0);
        txn(0, "rd_low",  64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, 64'd0, 1'b1, 0, 0, 0);
        txn(0, "rd_w4",   64'h8000_0014, MSIZE4, 8'h00, 64'd0, 64'h1122_3344_BEEF_7788, 1'b0, 0, 0, 0);
        txn(0, "rd_chg",  64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BEEF_7788, 1'b0, 0, 0, 1);
        txn(0, "rd10d",   64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BEEF_7788, 1'b0, 0, 0, 0);

        // reset during WAIT of a write must drop it
        txn(0, "wr20",    64'h8000_0020, MSIZE8, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 64'd0, 1'b0, 0, 0, 0);
        @(negedge clk);
        req[0].valid  = 1'b1;
        req[0].addr   = 64'h8000_0020;
        req[0].size   = MSIZE8;
        req[0].strobe = 8'hFF;
        req[0].data   = 64'h5A5A_5A5A_5A5A_5A5A;
        @(posedge clk);
        #1;
        chk("rstmid/busy_before", 64'(busy_w[0]), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle(0, "rstmid");
        chk("rstmid/addr_ok", 64'(resp[0].addr_ok), 64'd0);
        req[0].valid = 1'b0;
        for (int i = 0; i < 3; i++) lfsr_m[i] = 8'hA5;
        @(negedge clk);
        rst = 1'b1;
        txn(0, "rd20",    64'h8000_0020, MSIZE8, 8'h00, 64'd0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 0, 0, 0);

        // latency sweep
        txn(1, "l1_wr",   64'h8000_0008, MSIZE8, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 64'd0, 1'b0, 0, 0, 0);
        txn(1, "l1_rd",   64'h8000_0008, MSIZE8, 8'h00, 64'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 0, 0, 0);
        txn(1, "l1_mis",  64'h8000_0009, MSIZE4, 8'h00, 64'd0, 64'd0, 1'b1, 0, 0, 0);
        txn(2, "l5_wr",   64'h8000_0018, MSIZE8, 8'h81, 64'h7700_0000_0000_0066, 64'd0, 1'b0, 0, 0, 0);
        txn(2, "l5_wr2",  64'h8000_0018, MSIZE8, 8'h7E, 64'h0011_2233_4455_6600, 64'd0, 1'b0, 0, 0, 0);
        txn(2, "l5_rd",   64'h8000_0018, MSIZE8, 8'h00, 64'd0, 64'h7711_2233_4455_6666, 1'b0, 0, 0, 0);

        // back-to-back reads: valid held across RESP starts the next request
        for (int i = 0; i < 16; i++) begin
            if (i[0])
                txn(0, "b2b", 64'h8000_0000, MSIZE8, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0,
                    i != 0, i != 15, 0);
            else
                txn(0, "b2b", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BEEF_7788, 1'b0,
                    i != 0, i != 15, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Data-bus responder (slave end) of the dbus request/response protocol driven by the pipeline memory stage.
- Accepts one dbus_req_t at a time, serves it from an internal 64-bit word store after a configurable latency, and returns dbus_resp_t.
- Used as the simulation/FPGA data memory behind the memory stage / MMU path, and as the reference slave for dbus verification.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 64-bit words stored (4096 words = 32 KiB).
- LATENCY, 2, cycles from request acceptance to the data_ok cycle; legal range 1..15.
- BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- dreq  in  dbus_req_t  request bundle: valid, addr, size, strobe, data.
- dresp  out  dbus_resp_t  response bundle: addr_ok, data_ok, data.
- busy  out  1  high while a request is latched and not yet completed.
- err  out  1  one-cycle pulse coincident with data_ok when the completed request was out of range or misaligned.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0; busy=0; err=0; latency counter=0. Storage contents are not reset.
- Reset mid-transaction aborts the transaction; a pending write is not committed.
- States:
  - IDLE: if dreq.valid, latch addr/size/strobe/data, set busy=1, load counter=LATENCY-1, go to WAIT; if LATENCY=1, go straight to RESP.
  - WAIT: decrement the counter; when it reaches 0, go to RESP.
  - RESP: drive addr_ok=1 and data_ok=1 for exactly one cycle, then go to IDLE with busy=0.
- Latency: data_ok is high exactly LATENCY cycles after the edge on which valid was sampled in IDLE.
- Initiator contract: hold valid and the request stable until data_ok, and drop valid the cycle after.
- Request changes or valid dropping after acceptance are ignored; the latched request always completes.
- Valid seen in the cycle after RESP starts a new transaction.
- Address decode:
  - off = addr - BASE_ADDR (64-bit, wraps).
  - In range iff off < 2^DEPTH_LOG2 * 8.
  - index = off[DEPTH_LOG2+2:3].
- Misaligned iff addr[2:0] is not a multiple of the size: size 1=any, 2=addr[0]=0, 4=addr[1:0]=0, 8=addr[2:0]=0.
- Write (strobe≠0): on the RESP edge, byte i of the word takes data[8i+7:8i] where strobe[i]=1; other bytes are unchanged. dresp.data=0.
- Read (strobe=0): dresp.data = full 64-bit word at index, registered on entry to RESP; byte extraction is done by the initiator.
- Out of range or misaligned: write dropped, read returns 0, err=1 in the RESP cycle; the handshake still completes.
- Read-after-write to the same word returns the written data.

Optional Feature:
- Macro: DBUS_RESP_RAND_LAT_EN.
- Defined:
  - 8-bit Galois LFSR, seed 8'hA5 on reset, taps x^8+x^6+x^5+x^4+1.
  - Advances once per accepted request.
  - Counter load = LATENCY-1 + lfsr[1:0], so effective latency is LATENCY..LATENCY+3.
- Undefined: fixed latency LATENCY; no LFSR logic is instantiated.

Decomposition:
- common package: dbus_req_t, dbus_resp_t, strobe_t, msize_t (existing); add typedef dresp_state_t {IDLE, WAIT, RESP}.
- One sub-module: dbus_resp_lfsr (8-bit LFSR with advance enable), instantiated only under DBUS_RESP_RAND_LAT_EN.
- Byte-merge and alignment check stay inline as functions.

Test Plan:
- Basic access: write addr 8000_0010, strobe 8'hFF, data 64'h1122334455667788; then read the same address → data_ok two cycles after acceptance each time; read data=64'h1122334455667788, err=0.
- Partial write: over the above word, write addr 8000_0012, size 2, strobe 8'h0C, data 64'h0000_0000_BEEF_0000; read → 64'h11223344BEEF7788.
- Out of range / misaligned: write to 8000_0000+2^15 → err pulse, store unchanged; read addr 8000_0004 with size 8 → data 0, err=1, data_ok still asserted.
- Latency sweep: LATENCY=1 and LATENCY=5 → data_ok exactly 1 and 5 cycles after acceptance; busy high for those cycles; dresp all 0 otherwise.
- Reset mid-write: drop rst low during WAIT of a write to 8000_0020 → outputs zero immediately; after release, reading 8000_0020 returns the old value.
- Random latency (macro on): 16 back-to-back reads → each latency within LATENCY..LATENCY+3, sequence matching the LFSR model from seed 8'hA5.
